// File: rtl/softmax_pkg.sv
// Shared constants and FSM state encoding for the softmax sequencing controller.
package softmax_pkg;

    localparam int N_CLASSES = 10;
    localparam int DATA_W    = 8;
    localparam int IDX_W     = 4;
    localparam int WAIT_W    = 4;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/softmax_seq_ctrl.sv
// Sequencer: gathers logits into a vector, waits out the datapath latency, then drains per-class results.
// Optional feature: define SOFTMAX_SEQ_ARGMAX_EN to add out_argmax (running argmax over the loaded vector).
module softmax_seq_ctrl #(
    parameter int N_CLASSES = softmax_pkg::N_CLASSES,
    parameter int DATA_W    = softmax_pkg::DATA_W,
    parameter int DP_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [N_CLASSES*DATA_W-1:0]   dp_x,
    input  logic [DATA_W-1:0]             dp_mant,
    input  logic [N_CLASSES*DATA_W-1:0]   dp_exp,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [softmax_pkg::IDX_W-1:0] out_idx,
    output logic [DATA_W-1:0]             out_mant,
    output logic [DATA_W-1:0]             out_exp,
    output logic                          out_last,
    output logic                          busy
`ifdef SOFTMAX_SEQ_ARGMAX_EN
    ,
    output logic [softmax_pkg::IDX_W-1:0] out_argmax
`endif
);
    import softmax_pkg::*;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CLASSES - 1);
    localparam logic [WAIT_W-1:0] LAT_INIT = WAIT_W'(DP_LAT);

    state_t                        state_r;
    state_t                        state_next_s;
    logic [IDX_W-1:0]              load_cnt_r;
    logic [IDX_W-1:0]              out_idx_r;
    logic [WAIT_W-1:0]             wait_cnt_r;
    logic [N_CLASSES*DATA_W-1:0]   vec_r;
    logic [N_CLASSES*DATA_W-1:0]   exp_r;
    logic [DATA_W-1:0]             mant_r;
    logic                          in_ready_r;
    logic                          out_valid_r;
    logic                          busy_r;
    logic                          accept_s;
    logic                          take_s;

    // Handshake qualifiers and next-state selection.
    always_comb begin
        accept_s     = in_valid && in_ready_r;
        take_s       = out_valid_r && out_ready;
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && (load_cnt_r == LAST_IDX)) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd1) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (take_s && (out_idx_r == LAST_IDX)) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters, vector/result storage and the registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_cnt_r  <= 4'd0;
            wait_cnt_r  <= 4'd0;
            out_idx_r   <= 4'd0;
            vec_r       <= {(N_CLASSES*DATA_W){1'b0}};
            exp_r       <= {(N_CLASSES*DATA_W){1'b0}};
            mant_r      <= {DATA_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // Flags follow the next state so they line up with the state register.
            in_ready_r  <= (state_next_s == ST_LOAD);
            busy_r      <= (state_next_s != ST_LOAD);
            out_valid_r <= (state_next_s == ST_DRAIN);
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        vec_r[load_cnt_r*DATA_W +: DATA_W] <= in_data;
                        if (load_cnt_r == LAST_IDX) begin
                            load_cnt_r <= 4'd0;
                            wait_cnt_r <= LAT_INIT;
                        end else begin
                            load_cnt_r <= load_cnt_r + 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt_r <= wait_cnt_r - 4'd1;
                    if (wait_cnt_r == 4'd1) begin
                        mant_r <= dp_mant;
                        exp_r  <= dp_exp;
                    end
                end
                ST_DRAIN: begin
                    if (take_s) begin
                        if (out_idx_r == LAST_IDX) begin
                            out_idx_r <= 4'd0;
                        end else begin
                            out_idx_r <= out_idx_r + 4'd1;
                        end
                    end
                end
                default: begin
                    load_cnt_r <= 4'd0;
                    wait_cnt_r <= 4'd0;
                    out_idx_r  <= 4'd0;
                end
            endcase
        end
    end

`ifdef SOFTMAX_SEQ_ARGMAX_EN
    logic [DATA_W-1:0] max_val_r;
    logic [IDX_W-1:0]  argmax_r;

    // Running argmax; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_val_r <= {DATA_W{1'b0}};
            argmax_r  <= 4'd0;
        end else if (accept_s) begin
            if ((load_cnt_r == 4'd0) || (in_data > max_val_r)) begin
                max_val_r <= in_data;
                argmax_r  <= load_cnt_r;
            end
        end
    end

    assign out_argmax = argmax_r;
`endif

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign dp_x      = vec_r;
    assign out_idx   = out_idx_r;
    assign out_mant  = mant_r;
    assign out_exp   = exp_r[out_idx_r*DATA_W +: DATA_W];
    assign out_last  = (out_idx_r == LAST_IDX);

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Self-checking bench: table of vectors through a DP_LAT=1 instance, plus reset and DP_LAT=4 sequences.
module tb_softmax_seq_ctrl;
    import softmax_pkg::*;

    localparam int N = N_CLASSES;
    localparam int W = DATA_W;

    logic           clk = 1'b0;
    logic           rst_n, in_valid, out_ready;
    logic [W-1:0]   in_data, dp_mant;
    logic [N*W-1:0] dp_exp;

    logic           a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [N*W-1:0] a_dp_x;
    logic [3:0]     a_out_idx, a_argmax;
    logic [W-1:0]   a_out_mant, a_out_exp;
    logic           b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [N*W-1:0] b_dp_x;
    logic [3:0]     b_out_idx, b_argmax;
    logic [W-1:0]   b_out_mant, b_out_exp;

    logic           use4;
    logic           o_in_ready, o_valid, o_last, o_busy;
    logic [N*W-1:0] o_dp_x;
    logic [3:0]     o_idx, o_argmax;
    logic [W-1:0]   o_mant, o_exp;

    always #5 clk = ~clk;

    softmax_seq_ctrl #(.N_CLASSES(N), .DATA_W(W), .DP_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .dp_x(a_dp_x), .dp_mant(dp_mant), .dp_exp(dp_exp), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_idx(a_out_idx), .out_mant(a_out_mant), .out_exp(a_out_exp),
        .out_last(a_out_last), .busy(a_busy)
`ifdef SOFTMAX_SEQ_ARGMAX_EN
        , .out_argmax(a_argmax)
`endif
    );

    softmax_seq_ctrl #(.N_CLASSES(N), .DATA_W(W), .DP_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .dp_x(b_dp_x), .dp_mant(dp_mant), .dp_exp(dp_exp), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_idx(b_out_idx), .out_mant(b_out_mant), .out_exp(b_out_exp),
        .out_last(b_out_last), .busy(b_busy)
`ifdef SOFTMAX_SEQ_ARGMAX_EN
        , .out_argmax(b_argmax)
`endif
    );

`ifndef SOFTMAX_SEQ_ARGMAX_EN
    assign a_argmax = 4'd0;
    assign b_argmax = 4'd0;
`endif

    always_comb begin
        o_in_ready = use4 ? b_in_ready  : a_in_ready;
        o_valid    = use4 ? b_out_valid : a_out_valid;
        o_last     = use4 ? b_out_last  : a_out_last;
        o_busy     = use4 ? b_busy      : a_busy;
        o_dp_x     = use4 ? b_dp_x      : a_dp_x;
        o_idx      = use4 ? b_out_idx   : a_out_idx;
        o_argmax   = use4 ? b_argmax    : a_argmax;
        o_mant     = use4 ? b_out_mant  : a_out_mant;
        o_exp      = use4 ? b_out_exp   : a_out_exp;
    end

    typedef struct packed {
        logic [N*W-1:0] data;   // element k at [k*W +: W]
        logic           gaps;
        logic [3:0]     stall;  // 15 = no stall
        logic [W-1:0]   mant;
        logic [W-1:0]   eb;     // expected exp[k] = eb + k
    } vec_t;

    typedef struct packed {
        logic [3:0]   idx;
        logic [W-1:0] mant;
        logic [W-1:0] exp;
        logic         last;
    } res_t;

    res_t           sb[$];
    vec_t           tbl[5];
    logic [N*W-1:0] cur_x;
    int             checks = 0;
    int             errors = 0;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Listing order is element 0 first (most significant byte of the argument).
    function automatic logic [N*W-1:0] mk(input logic [N*W-1:0] lst);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = lst[(N-1-k)*W +: W];
        return r;
    endfunction

    function automatic logic [3:0] model_argmax(input logic [N*W-1:0] d);
        logic [3:0]   best = 4'd0;
        logic [W-1:0] bv   = d[W-1:0];
        for (int k = 1; k < N; k++) begin
            if (d[k*W +: W] > bv) begin
                bv   = d[k*W +: W];
                best = 4'(k);
            end
        end
        return best;
    endfunction

    task automatic set_dp(input logic [W-1:0] m, input logic [W-1:0] eb);
        dp_mant = m;
        for (int k = 0; k < N; k++) dp_exp[k*W +: W] = eb + W'(k);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = v.data[k*W +: W];
            tick();
            chk($sformatf("busy_after_accept%0d", k), {79'd0, o_busy}, {79'd0, (k == N-1)});
            if (v.gaps && k < N-1) begin
                in_valid = 1'b0;
                in_data  = 8'hFF;
                tick();
            end
        end
        in_valid = 1'b0;
        chk("out_valid_in_wait", {79'd0, o_valid}, 80'd0);
        chk("dp_x_loaded", o_dp_x, v.data);
        cur_x = v.data;
`ifdef SOFTMAX_SEQ_ARGMAX_EN
        chk("argmax", {76'd0, o_argmax}, {76'd0, model_argmax(v.data)});
`endif
        for (int k = 0; k < N; k++)
            sb.push_back('{idx: 4'(k), mant: v.mant, exp: v.eb + W'(k), last: (k == N-1)});
    endtask

    task automatic drain(input logic [3:0] stall);
        int   cyc     = 0;
        logic stalled = 1'b0;
        res_t e;
        out_ready = 1'b1;
        while (sb.size() > 0 && cyc < 200) begin
            cyc++;
            if (o_valid) begin
                e = sb[0];
                if (e.idx == stall && !stalled) begin
                    stalled   = 1'b1;
                    out_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        tick();
                        chk("stall_valid", {79'd0, o_valid}, {79'd0, 1'b1});
                        chk("stall_idx", {76'd0, o_idx}, {76'd0, e.idx});
                        chk("stall_exp", {72'd0, o_exp}, {72'd0, e.exp});
                    end
                    out_ready = 1'b1;
                end
                chk($sformatf("idx%0d", e.idx), {76'd0, o_idx}, {76'd0, e.idx});
                chk($sformatf("mant%0d", e.idx), {72'd0, o_mant}, {72'd0, e.mant});
                chk($sformatf("exp%0d", e.idx), {72'd0, o_exp}, {72'd0, e.exp});
                chk($sformatf("last%0d", e.idx), {79'd0, o_last}, {79'd0, e.last});
                chk("dp_x_held", o_dp_x, cur_x);
                void'(sb.pop_front());
            end
            tick();
        end
        if (sb.size() > 0) chk("drain_timeout", 80'(sb.size()), 80'd0);
        out_ready = 1'b0;
        chk("post_drain_in_ready", {79'd0, o_in_ready}, {79'd0, 1'b1});
        chk("post_drain_valid", {79'd0, o_valid}, 80'd0);
        chk("post_drain_busy", {79'd0, o_busy}, 80'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N*W-1:0] base;
        logic [N*W-1:0] lst;
        use4    = 1'b0;
        in_data = 8'h00;
        set_dp(8'hA5, 8'h01);

        lst  = 80'h01030507113302251206;
        base = mk(lst);
        tbl[0] = '{data: base, gaps: 1'b0, stall: 4'd3, mant: 8'hA5, eb: 8'h01};
        lst    = 80'h07070707070707070707;
        tbl[1] = '{data: mk(lst), gaps: 1'b0, stall: 4'd15, mant: 8'h3C, eb: 8'h20};
        tbl[2] = '{data: base, gaps: 1'b1, stall: 4'd15, mant: 8'hA5, eb: 8'h01};
        lst    = 80'hFF0080FF1020304050FE;
        tbl[3] = '{data: mk(lst), gaps: 1'b0, stall: 4'd9, mant: 8'h00, eb: 8'hF0};
        lst    = 80'h00010203040506070809;
        tbl[4] = '{data: mk(lst), gaps: 1'b1, stall: 4'd0, mant: 8'h7E, eb: 8'h40};

        do_reset();
        chk("rst_in_ready", {79'd0, o_in_ready}, {79'd0, 1'b1});
        chk("rst_busy", {79'd0, o_busy}, 80'd0);
        chk("rst_valid", {79'd0, o_valid}, 80'd0);
        chk("rst_dp_x", o_dp_x, 80'd0);
        chk("rst_idx", {76'd0, o_idx}, 80'd0);
        chk("rst_mant", {72'd0, o_mant}, 80'd0);
        chk("rst_exp", {72'd0, o_exp}, 80'd0);
        chk("rst_argmax", {76'd0, o_argmax}, 80'd0);

        for (int i = 0; i < 5; i++) begin
            set_dp(tbl[i].mant, tbl[i].eb);
            load_vec(tbl[i]);
            tick();
            chk("out_valid_lat1", {79'd0, o_valid}, {79'd0, 1'b1});
            drain(tbl[i].stall);
        end

        // Reset after the sixth accept discards the partial vector.
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = tbl[3].data[k*W +: W];
            tick();
        end
        do_reset();
        chk("midload_rst_in_ready", {79'd0, o_in_ready}, {79'd0, 1'b1});
        chk("midload_rst_busy", {79'd0, o_busy}, 80'd0);
        chk("midload_rst_dp_x", o_dp_x, 80'd0);
        set_dp(8'hA5, 8'h01);
        load_vec(tbl[0]);
        tick();
        drain(4'd15);

        // DP_LAT=4: correct datapath values only on the capture cycle.
        do_reset();
        use4 = 1'b1;
        set_dp(8'h11, 8'hE0);
        load_vec(tbl[0]);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("lat4_valid_c%0d", c), {79'd0, o_valid}, 80'd0);
            chk($sformatf("lat4_busy_c%0d", c), {79'd0, o_busy}, {79'd0, 1'b1});
        end
        set_dp(8'hA5, 8'h01);
        tick();
        chk("lat4_valid_drain", {79'd0, o_valid}, {79'd0, 1'b1});
        set_dp(8'h5A, 8'h77);
        drain(4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
